// File: rtl/rvseed_arb_pkg.sv
// Shared constants for the RVSEED AXI read-channel arbiter: FSM state
// encoding, AXI RRESP codes and master indices.
package rvseed_arb_pkg;

  // FSM state encoding (ABORT is only reachable with the read timeout enabled)
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  // AXI read response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Master indices: 0 = instruction fetch, 1 = load/store data port
  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/rvseed_rd_arbiter_if.sv
// AXI read channel (AR + R) bundle. The master modport is the side that
// issues addresses and consumes data; the slave modport is the opposite.
interface rvseed_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) ();

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  modport master (
    output arvalid, araddr, arid, arlen, rready,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, rready,
    output arready, rvalid, rdata, rresp, rid, rlast
  );

endinterface

// File: rtl/rvseed_rr_arb2.sv
// Two-way round-robin picker. Purely combinational: given the request
// vector and the index of the master served last, returns the winner.
module rvseed_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       any_req,
  output logic       winner
);

  assign any_req = |req;

  // On a tie the master that was not served last goes; otherwise the lone
  // requester wins (req[1] alone selects master 1, req[0] alone master 0).
  assign winner = (req == 2'b11) ? ~rr_last : req[1];

endmodule

// File: rtl/rvseed_rd_arbiter.sv
// Two-master, one-slave AXI read arbiter for the RVSEED core.
// Master 0 is the instruction fetch port, master 1 the load data port.
// One transaction is outstanding at a time; R beats are routed back by the
// registered grant, not by ID. Grants are round-robin.
// Optional read timeout: define RVSEED_RD_ARB_TIMEOUT_EN to add the idle
// beat counter, the ABORT state and the sticky arb_timeout output.
module rvseed_rd_arbiter
  import rvseed_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  rvseed_rd_arbiter_if.slave  m0,
  rvseed_rd_arbiter_if.slave  m1,
  rvseed_rd_arbiter_if.master s,
  output logic                arb_busy,
  output logic                arb_grant
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
  ,
  output logic                arb_timeout
`endif
);

  logic [1:0] state_reg, state_next;
  logic       grant_reg, grant_next;
  logic       rr_last_reg, rr_last_next;

  // Per-master views gathered into vectors so the routing can be indexed
  logic [1:0]        m_arvalid, m_arready, m_rready, m_rvalid;
  logic [ADDR_W-1:0] m_araddr [2];
  logic [ID_W-1:0]   m_arid   [2];
  logic [LEN_W-1:0]  m_arlen  [2];

  logic              pick_any, pick_winner;
  logic              r_valid, r_last, s_rready, beat_acc;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic [ID_W-1:0]   r_id;

`ifdef RVSEED_RD_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ID_W-1:0]  arid_reg, arid_next;
  logic             timeout_reg, timeout_next;
`endif

  assign m_arvalid   = {m1.arvalid, m0.arvalid};
  assign m_rready    = {m1.rready,  m0.rready};
  assign m_araddr[0] = m0.araddr;
  assign m_araddr[1] = m1.araddr;
  assign m_arid[0]   = m0.arid;
  assign m_arid[1]   = m1.arid;
  assign m_arlen[0]  = m0.arlen;
  assign m_arlen[1]  = m1.arlen;

  rvseed_rr_arb2 u_rr (
    .req     (m_arvalid),
    .rr_last (rr_last_reg),
    .any_req (pick_any),
    .winner  (pick_winner)
  );

  // Only the granted master sees arready/rvalid; the other is held off.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mst
    assign m_arready[gi] = (state_reg == ADDR) && (grant_reg == 1'(gi)) && s.arready;
    assign m_rvalid[gi]  = (grant_reg == 1'(gi)) && r_valid;
  end

  assign m0.arready = m_arready[0];
  assign m1.arready = m_arready[1];
  assign m0.rvalid  = m_rvalid[0];
  assign m1.rvalid  = m_rvalid[1];
  assign m0.rdata   = r_data;
  assign m1.rdata   = r_data;
  assign m0.rresp   = r_resp;
  assign m1.rresp   = r_resp;
  assign m0.rid     = r_id;
  assign m1.rid     = r_id;
  assign m0.rlast   = r_last;
  assign m1.rlast   = r_last;

  // AR payload follows the registered grant, so there is no path from any
  // master arvalid to s.arvalid.
  assign s.arvalid = (state_reg == ADDR);
  assign s.araddr  = m_araddr[grant_reg];
  assign s.arid    = m_arid[grant_reg];
  assign s.arlen   = m_arlen[grant_reg];
  assign s.rready  = s_rready;

  assign beat_acc  = s.rvalid && s_rready;
  assign arb_busy  = (state_reg != IDLE);
  assign arb_grant = grant_reg;

  // R return path: passthrough in DATA, synthetic error beat in ABORT.
  always_comb begin
    r_valid  = 1'b0;
    r_data   = s.rdata;
    r_resp   = s.rresp;
    r_id     = s.rid;
    r_last   = s.rlast;
    s_rready = 1'b0;
    case (state_reg)
      DATA: begin
        r_valid  = s.rvalid;
        s_rready = m_rready[grant_reg];
      end
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
      ABORT: begin
        r_valid  = 1'b1;
        r_data   = '0;
        r_resp   = SLVERR;
        r_id     = arid_reg;
        r_last   = 1'b1;
        s_rready = 1'b1;  // sink any stray beats from the slave
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic for the arbitration FSM.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_last_next = rr_last_reg;
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
    cnt_next     = '0;
    arid_next    = arid_reg;
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_winner;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (s.arready) begin
          state_next = DATA;
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
          arid_next  = m_arid[grant_reg];
`endif
        end
      end
      DATA: begin
        if (beat_acc && s.rlast) begin
          rr_last_next = grant_reg;
          state_next   = IDLE;
        end
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
        else if (beat_acc) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYC)) begin
          state_next = ABORT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
      ABORT: begin
        if (m_rready[grant_reg]) begin
          rr_last_next = grant_reg;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      grant_reg   <= MST_IFU;
      rr_last_reg <= MST_LSU;  // master 0 wins the first tie
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
      cnt_reg     <= '0;
      arid_reg    <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_last_reg <= rr_last_next;
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      arid_reg    <= arid_next;
      timeout_reg <= timeout_next;
`endif
    end
  end

`ifdef RVSEED_RD_ARB_TIMEOUT_EN
  assign arb_timeout = timeout_reg;
`endif

endmodule

// File: tb/tb_rvseed_rd_arbiter.sv
// Self-checking bench for rvseed_rd_arbiter. The slave and both masters are
// driven from one directed initial block with randomized payloads; the
// expected winner, routing and data come from a transaction-level model.
module tb_rvseed_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic arb_busy;
  logic arb_grant;
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
  logic arb_timeout;
`endif

  rvseed_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) m0_if ();
  rvseed_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) m1_if ();
  rvseed_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) s_if ();

  rvseed_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .arb_busy    (arb_busy),
    .arb_grant   (arb_grant)
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
    ,
    .arb_timeout (arb_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: which master was served last, and each master's request.
  int            exp_last = 1;
  logic [AW-1:0] addr_q [2];
  logic [IW-1:0] id_q   [2];
  logic [LW-1:0] len_q  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic g_arready(input int m);
    return (m == 1) ? m1_if.arready : m0_if.arready;
  endfunction
  function automatic logic g_rvalid(input int m);
    return (m == 1) ? m1_if.rvalid : m0_if.rvalid;
  endfunction
  function automatic logic [DW-1:0] g_rdata(input int m);
    return (m == 1) ? m1_if.rdata : m0_if.rdata;
  endfunction
  function automatic logic [1:0] g_rresp(input int m);
    return (m == 1) ? m1_if.rresp : m0_if.rresp;
  endfunction
  function automatic logic [IW-1:0] g_rid(input int m);
    return (m == 1) ? m1_if.rid : m0_if.rid;
  endfunction
  function automatic logic g_rlast(input int m);
    return (m == 1) ? m1_if.rlast : m0_if.rlast;
  endfunction

  task automatic set_rready(input int m, input logic v);
    if (m == 1) m1_if.rready = v;
    else        m0_if.rready = v;
  endtask

  // Raise a new request on master m unless it is already requesting.
  task automatic raise_req(input int m, input int len, input logic [AW-1:0] addr);
    if (m == 1 && m1_if.arvalid) return;
    if (m == 0 && m0_if.arvalid) return;
    addr_q[m] = addr;
    id_q[m]   = IW'($urandom);
    len_q[m]  = LW'(len);
    if (m == 1) begin
      m1_if.arvalid = 1'b1; m1_if.araddr = addr; m1_if.arid = id_q[m]; m1_if.arlen = len_q[m];
    end else begin
      m0_if.arvalid = 1'b1; m0_if.araddr = addr; m0_if.arid = id_q[m]; m0_if.arlen = len_q[m];
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 1) m1_if.arvalid = 1'b0;
    else        m0_if.arvalid = 1'b0;
  endtask

  // Address phase: predict the winner, check the AR mux and handshake.
  task automatic ar_phase(output int win);
    int n;
    if (m0_if.arvalid && m1_if.arvalid) win = (exp_last == 0) ? 1 : 0;
    else                                win = m1_if.arvalid ? 1 : 0;
    #1;
    chk("ar_registered", 64'(s_if.arvalid), 64'(0));
    tick();
    chk("ar_valid", 64'(s_if.arvalid), 64'(1));
    chk("grant", 64'(arb_grant), 64'(win));
    chk("busy_addr", 64'(arb_busy), 64'(1));
    chk("araddr", 64'(s_if.araddr), 64'(addr_q[win]));
    chk("arid", 64'(s_if.arid), 64'(id_q[win]));
    chk("arlen", 64'(s_if.arlen), 64'(len_q[win]));
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("ar_hold", 64'(s_if.arvalid), 64'(1));
      chk("arready_wait", 64'(g_arready(win)), 64'(0));
    end
    s_if.arready = 1'b1;
    #1;
    chk("arready_g", 64'(g_arready(win)), 64'(1));
    chk("arready_o", 64'(g_arready(1 - win)), 64'(0));
    tick();
    s_if.arready = 1'b0;
    drop_req(win);
  endtask

  // Data phase: slave sends len+1 beats; each accepted beat is checked.
  task automatic data_phase(input int win, input bit gaps, input bit stall_b2,
                            input logic [1:0] resp, input bit late0,
                            input bit fix, input logic [DW-1:0] fixd);
    int            len;
    int            tries;
    bit            done, sv, mr;
    logic [DW-1:0] d;
    len = int'(len_q[win]);
    for (int b = 0; b <= len; b++) begin
      d     = (fix && b == 0) ? fixd : DW'($urandom);
      tries = 0;
      done  = 1'b0;
      while (!done && tries < 40) begin
        sv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        mr = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stall_b2 && b == 2 && tries < 2) begin
          sv = 1'b1;
          mr = 1'b0;
        end
        s_if.rvalid = sv;
        s_if.rdata  = d;
        s_if.rresp  = resp;
        s_if.rid    = id_q[win];
        s_if.rlast  = (b == len);
        set_rready(win, mr);
        set_rready(1 - win, 1'($urandom));
        if (late0 && win == 1 && b == 1) raise_req(0, 0, AW'($urandom));
        #1;
        chk("rvalid_g", 64'(g_rvalid(win)), 64'(sv));
        chk("rvalid_o", 64'(g_rvalid(1 - win)), 64'(0));
        chk("s_rready", 64'(s_if.rready), 64'(mr));
        chk("ar_quiet", 64'(s_if.arvalid), 64'(0));
        if (sv) begin
          chk("rdata", 64'(g_rdata(win)), 64'(d));
          chk("rresp", 64'(g_rresp(win)), 64'(resp));
          chk("rid", 64'(g_rid(win)), 64'(id_q[win]));
          chk("rlast", 64'(g_rlast(win)), 64'(b == len));
        end
        if (late0 && m0_if.arvalid) chk("late_arready", 64'(m0_if.arready), 64'(0));
        tick();
        done = sv && mr;
        tries++;
      end
      if (!done) chk("beat_bound", 64'(0), 64'(1));
    end
    s_if.rvalid = 1'b0;
    s_if.rlast  = 1'b0;
    set_rready(0, 1'b0);
    set_rready(1, 1'b0);
    #1;
    chk("busy_after", 64'(arb_busy), 64'(0));
    exp_last = win;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_last = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int win;
    int r;
    m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0; m0_if.rready = 0;
    m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0; m1_if.rready = 0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0; s_if.rid = '0; s_if.rlast = 0;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_grant", 64'(arb_grant), 64'(0));
    chk("rst_s_arvalid", 64'(s_if.arvalid), 64'(0));
    chk("rst_s_rready", 64'(s_if.rready), 64'(0));
    chk("rst_m0_arready", 64'(m0_if.arready), 64'(0));
    chk("rst_m1_rvalid", 64'(m1_if.rvalid), 64'(0));
`ifdef RVSEED_RD_ARB_TIMEOUT_EN
    chk("rst_timeout", 64'(arb_timeout), 64'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Single IFU read returning 0x13
    raise_req(0, 0, 32'h0000_0100);
    ar_phase(win);
    data_phase(win, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0013);

    // Simultaneous requests after reset: continuous contention alternates
    pulse_reset();
    raise_req(0, 0, AW'($urandom));
    raise_req(1, 0, AW'($urandom));
    for (int i = 0; i < 4; i++) begin
      ar_phase(win);
      chk("fair_order", 64'(arb_grant), 64'(i % 2));
      data_phase(win, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, '0);
      if (i < 3) raise_req(win, 0, AW'($urandom));
      else       drop_req(1 - win);
    end

    // LSU burst of 4 with gaps, beat-2 stall, IFU request arriving mid-burst
    raise_req(1, 3, AW'($urandom));
    ar_phase(win);
    data_phase(win, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, '0);
    ar_phase(win);
    chk("late_ifu_grant", 64'(win), 64'(0));
    data_phase(win, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, '0);

    // SLVERR forwarded, then a normal read
    raise_req(0, 0, AW'($urandom));
    ar_phase(win);
    data_phase(win, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, '0);
    raise_req(1, 1, AW'($urandom));
    ar_phase(win);
    data_phase(win, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0);

    // Reset while mid-burst in DATA
    raise_req(1, 3, AW'($urandom));
    ar_phase(win);
    s_if.rvalid = 1'b1; s_if.rdata = DW'($urandom); s_if.rid = id_q[1]; s_if.rlast = 1'b0;
    m1_if.rready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 64'(arb_busy), 64'(0));
    chk("mid_rst_s_rready", 64'(s_if.rready), 64'(0));
    chk("mid_rst_m0_rvalid", 64'(m0_if.rvalid), 64'(0));
    chk("mid_rst_m1_rvalid", 64'(m1_if.rvalid), 64'(0));
    rst_n = 1'b1;
    s_if.rvalid = 1'b0;
    m1_if.rready = 1'b0;
    exp_last = 1;
    raise_req(0, 0, AW'($urandom));
    raise_req(1, 0, AW'($urandom));
    ar_phase(win);
    chk("post_rst_grant", 64'(win), 64'(0));
    data_phase(win, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, '0);
    ar_phase(win);
    data_phase(win, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, '0);

    // Randomized traffic
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(1, 3);
      if (r[0]) raise_req(0, $urandom_range(0, 3), AW'($urandom));
      if (r[1]) raise_req(1, $urandom_range(0, 3), AW'($urandom));
      ar_phase(win);
      data_phase(win, 1'b1, 1'b0, 2'($urandom), 1'b0, 1'b0, '0);
    end
    while (m0_if.arvalid || m1_if.arvalid) begin
      ar_phase(win);
      data_phase(win, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, '0);
    end

`ifdef RVSEED_RD_ARB_TIMEOUT_EN
    // Slave never answers: synthetic SLVERR beat after the idle budget
    begin
      int n;
      raise_req(0, 0, AW'($urandom));
      ar_phase(win);
      n = 0;
      while (!m0_if.rvalid && n < 400) begin
        chk("to_no_early_timeout", 64'(arb_timeout), 64'(0));
        tick();
        n++;
      end
      chk("to_window", 64'(n >= 255 && n <= 257), 64'(1));
      chk("to_rvalid", 64'(m0_if.rvalid), 64'(1));
      chk("to_rresp", 64'(m0_if.rresp), 64'(2'b10));
      chk("to_rlast", 64'(m0_if.rlast), 64'(1));
      chk("to_rdata", 64'(m0_if.rdata), 64'(0));
      chk("to_rid", 64'(m0_if.rid), 64'(id_q[0]));
      chk("to_s_rready", 64'(s_if.rready), 64'(1));
      m0_if.rready = 1'b1;
      tick();
      m0_if.rready = 1'b0;
      chk("to_busy", 64'(arb_busy), 64'(0));
      chk("to_sticky", 64'(arb_timeout), 64'(1));
      repeat (3) tick();
      chk("to_still_sticky", 64'(arb_timeout), 64'(1));
      pulse_reset();
      chk("to_cleared", 64'(arb_timeout), 64'(0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
